// File: rtl/deserializador_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : deserializador_demux_pkg
//  Description : Shared definitions for the serial-to-parallel capture block:
//                FSM state encodings (also reused by the game control unit
//                for state display) and the index-width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package deserializador_demux_pkg;

  // Fixed encodings; 2'b11 is unused and recovers to INICIAL.
  typedef enum logic [1:0] {
    INICIAL = 2'b00,
    RECEBE  = 2'b01,
    FIM     = 2'b10
  } estado_t;

  // Index width for an N-position demux. Clamped to 1 so a degenerate N
  // never yields a zero-width vector.
  function automatic int indice_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/deserializador_demux_if.sv
`default_nettype none
// ============================================================================
//  Module      : deserializador_demux_if
//  Description : Bundle of the capture block's control/data signals.
//  Signals     : iniciar  - start/restart a word capture
//                amostra  - sample strobe
//                D        - serial data bit
//                Q        - assembled word (first bit in LSB)
//                indice   - position the next sample will write
//                ocupado  - high while receiving
//                pronto   - one-cycle pulse when a word is complete
//  Modports    : master (drives iniciar/amostra/D), slave (the capture block)
//  Revision    : 1.0 - initial release
// ============================================================================
interface deserializador_demux_if
  import deserializador_demux_pkg::*;
#(
  parameter int N = 4
) ();

  localparam int W = indice_w(N);

  logic         iniciar;
  logic         amostra;
  logic         D;
  logic [N-1:0] Q;
  logic [W-1:0] indice;
  logic         ocupado;
  logic         pronto;

  modport master (
    output iniciar, amostra, D,
    input  Q, indice, ocupado, pronto
  );

  modport slave (
    input  iniciar, amostra, D,
    output Q, indice, ocupado, pronto
  );

endinterface
`default_nettype wire

// File: rtl/deserializador_demux_contador_m.sv
`default_nettype none
// ============================================================================
//  Module      : contador_m
//  Description : Modulo-N counter with synchronous clear and enable. The wrap
//                at N-1 is explicit, so non-power-of-two N never overflows
//                into unused codes.
//  Ports       : clock   - clock
//                reset   - synchronous active-high reset
//                clr_i   - synchronous clear (priority over enable)
//                en_i    - count enable
//                count_o - current count, 0..N-1
//                fim_o   - terminal count (count_o == N-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_m
  import deserializador_demux_pkg::*;
#(
  parameter int N = 4
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     clr_i,
  input  wire logic                     en_i,
  output logic      [indice_w(N)-1:0]   count_o,
  output logic                          fim_o
);

  localparam int W = indice_w(N);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = fim_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign fim_o   = (count_q == W'(N - 1));

endmodule
`default_nettype wire

// File: rtl/deserializador_demux.sv
`default_nettype none
// ============================================================================
//  Module      : deserializador_demux
//  Description : Serial-to-parallel capture. Each sample strobe writes D into
//                Q[indice] (1:N demux) and advances indice; after N samples
//                the FSM visits FIM for one cycle, pulsing pronto with Q
//                complete and stable.
//  Ports       : clock - clock (rising edge)
//                reset - synchronous active-high reset
//                bus   - deserializador_demux_if.slave
//                        (iniciar, amostra, D in; Q, indice, ocupado, pronto out)
//  Revision    : 1.0 - initial release
// ============================================================================
module deserializador_demux
  import deserializador_demux_pkg::*;
#(
  parameter int N = 4
) (
  input  wire logic             clock,
  input  wire logic             reset,
  deserializador_demux_if.slave bus
);

  localparam int W = indice_w(N);

  estado_t      estado_q;
  estado_t      estado_d;
  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] we;
  logic [W-1:0] indice;
  logic         fim_cont;
  logic         limpa;    // accepted iniciar: clear Q and index
  logic         avanca;   // accepted sample: write Q[indice], step index

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    limpa    = 1'b0;
    avanca   = 1'b0;
    case (estado_q)
      INICIAL: begin
        if (bus.iniciar) begin
          estado_d = RECEBE;
          limpa    = 1'b1;
        end
      end
      RECEBE: begin
        // iniciar wins over amostra: the simultaneous sample is discarded.
        if (bus.iniciar) begin
          limpa = 1'b1;
        end else if (bus.amostra) begin
          avanca = 1'b1;
          if (fim_cont) begin
            estado_d = FIM;
          end
        end
      end
      FIM: begin
        // Going straight back to RECEBE keeps the word period at N+1.
        if (bus.iniciar) begin
          estado_d = RECEBE;
          limpa    = 1'b1;
        end else begin
          estado_d = INICIAL;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Position counter; its terminal count closes the word.
  // --------------------------------------------------------------------------
  contador_m #(
    .N (N)
  ) u_contador (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (limpa),
    .en_i    (avanca),
    .count_o (indice),
    .fim_o   (fim_cont)
  );

  // --------------------------------------------------------------------------
  // Demux write enables and word register
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_we
    assign we[i] = avanca && (indice == W'(i));
  end

  always_comb begin
    q_d = q_q;
    if (limpa) begin
      q_d = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (we[i]) begin
          q_d[i] = bus.D;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Status outputs are pure decodes of the registered state.
  assign bus.Q       = q_q;
  assign bus.indice  = indice;
  assign bus.ocupado = (estado_q == RECEBE);
  assign bus.pronto  = (estado_q == FIM);

endmodule
`default_nettype wire

// File: tb/tb_deserializador_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deserializador_demux
//  Description : Directed self-checking bench for deserializador_demux with
//                N=4, plus N=3 and N=5 instances for the wrap behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializador_demux;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cycle;

  deserializador_demux_if #(.N(4)) if4 ();
  deserializador_demux_if #(.N(3)) if3 ();
  deserializador_demux_if #(.N(5)) if5 ();

  deserializador_demux #(.N(4)) u_dut4 (.clock(clk), .reset(rst), .bus(if4));
  deserializador_demux #(.N(3)) u_dut3 (.clock(clk), .reset(rst), .bus(if3));
  deserializador_demux #(.N(5)) u_dut5 (.clock(clk), .reset(rst), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (if4.Q !== 4'b0000) begin n_fail++; $display("FAIL reset_Q: got %b want 0000", if4.Q); end
    n_checks++; if (if4.indice !== 2'd0) begin n_fail++; $display("FAIL reset_indice: got %0d want 0", if4.indice); end
    n_checks++; if (if4.ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b want 0", if4.ocupado); end
    n_checks++; if (if4.pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto: got %b want 0", if4.pronto); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    logic [1:0] exp_idx;
    int         np;
    bits = 4'b1101;
    np   = 0;
    if4.iniciar = 1'b1;
    tick();
    if4.iniciar = 1'b0;
    n_checks++; if (if4.ocupado !== 1'b1) begin n_fail++; $display("FAIL basic_ocupado_start: got %b want 1", if4.ocupado); end
    n_checks++; if (if4.indice !== 2'd0) begin n_fail++; $display("FAIL basic_indice_start: got %0d want 0", if4.indice); end
    for (int i = 0; i < 4; i++) begin
      if4.amostra = 1'b1;
      if4.D       = bits[i];
      tick();
      if (if4.pronto === 1'b1) np++;
      exp_idx = 2'((i + 1) % 4);
      n_checks++; if (if4.indice !== exp_idx) begin n_fail++; $display("FAIL basic_indice_step%0d: got %0d want %0d", i, if4.indice, exp_idx); end
    end
    if4.amostra = 1'b0;
    n_checks++; if (if4.pronto !== 1'b1) begin n_fail++; $display("FAIL basic_pronto: got %b want 1", if4.pronto); end
    n_checks++; if (if4.ocupado !== 1'b0) begin n_fail++; $display("FAIL basic_ocupado_end: got %b want 0", if4.ocupado); end
    n_checks++; if (if4.Q !== 4'b1101) begin n_fail++; $display("FAIL basic_Q: got %b want 1101", if4.Q); end
    tick();
    if (if4.pronto === 1'b1) np++;
    n_checks++; if (if4.Q !== 4'b1101) begin n_fail++; $display("FAIL basic_Q_hold: got %b want 1101", if4.Q); end
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL basic_pronto_count: got %0d want 1", np); end
  endtask

  task automatic test_gapped();
    logic [3:0] bits;
    int         np;
    bits = 4'b0110;
    np   = 0;
    if4.iniciar = 1'b1;
    tick();
    if4.iniciar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if4.amostra = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if4.D = ~bits[i];
        tick();
        if (if4.pronto === 1'b1) np++;
        n_checks++; if (if4.indice !== 2'(i)) begin n_fail++; $display("FAIL gapped_indice_hold%0d: got %0d want %0d", i, if4.indice, i); end
      end
      if4.amostra = 1'b1;
      if4.D       = bits[i];
      tick();
      if (if4.pronto === 1'b1) np++;
    end
    if4.amostra = 1'b0;
    n_checks++; if (if4.Q !== 4'b0110) begin n_fail++; $display("FAIL gapped_Q: got %b want 0110", if4.Q); end
    tick();
    if (if4.pronto === 1'b1) np++;
    tick();
    if (if4.pronto === 1'b1) np++;
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL gapped_pronto_count: got %0d want 1", np); end
  endtask

  task automatic test_restart();
    if4.iniciar = 1'b1;
    tick();
    if4.iniciar = 1'b0;
    if4.amostra = 1'b1;
    if4.D       = 1'b1;
    tick();
    tick();
    n_checks++; if (if4.Q !== 4'b0011) begin n_fail++; $display("FAIL restart_Q_partial: got %b want 0011", if4.Q); end
    if4.iniciar = 1'b1;
    tick();
    if4.iniciar = 1'b0;
    n_checks++; if (if4.Q !== 4'b0000) begin n_fail++; $display("FAIL restart_Q_clear: got %b want 0000", if4.Q); end
    n_checks++; if (if4.indice !== 2'd0) begin n_fail++; $display("FAIL restart_indice: got %0d want 0", if4.indice); end
    n_checks++; if (if4.ocupado !== 1'b1) begin n_fail++; $display("FAIL restart_ocupado: got %b want 1", if4.ocupado); end
    for (int i = 0; i < 4; i++) tick();
    if4.amostra = 1'b0;
    n_checks++; if (if4.Q !== 4'b1111) begin n_fail++; $display("FAIL restart_Q_full: got %b want 1111", if4.Q); end
    n_checks++; if (if4.pronto !== 1'b1) begin n_fail++; $display("FAIL restart_pronto: got %b want 1", if4.pronto); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] w1;
    logic [3:0] w2;
    int         c1;
    w1 = 4'b1001;
    w2 = 4'b0110;
    if4.iniciar = 1'b1;
    tick();
    if4.iniciar = 1'b0;
    if4.amostra = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if4.D = w1[i];
      tick();
    end
    c1 = cycle;
    n_checks++; if (if4.pronto !== 1'b1) begin n_fail++; $display("FAIL b2b_pronto1: got %b want 1", if4.pronto); end
    n_checks++; if (if4.Q !== 4'b1001) begin n_fail++; $display("FAIL b2b_Q1: got %b want 1001", if4.Q); end
    if4.iniciar = 1'b1;
    if4.D       = 1'b1;
    tick();
    if4.iniciar = 1'b0;
    n_checks++; if (if4.ocupado !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle: ocupado got %b want 1", if4.ocupado); end
    n_checks++; if (if4.Q !== 4'b0000) begin n_fail++; $display("FAIL b2b_Q_clear: got %b want 0000", if4.Q); end
    for (int i = 0; i < 4; i++) begin
      if4.D = w2[i];
      tick();
    end
    if4.amostra = 1'b0;
    n_checks++; if (if4.pronto !== 1'b1) begin n_fail++; $display("FAIL b2b_pronto2: got %b want 1", if4.pronto); end
    n_checks++; if (if4.Q !== 4'b0110) begin n_fail++; $display("FAIL b2b_Q2: got %b want 0110", if4.Q); end
    n_checks++; if ((cycle - c1) !== 5) begin n_fail++; $display("FAIL b2b_period: got %0d want 5", cycle - c1); end
    tick();
  endtask

  task automatic test_reset_ignore();
    logic [3:0] w;
    w = 4'b1011;
    if4.iniciar = 1'b1;
    tick();
    if4.iniciar = 1'b0;
    if4.amostra = 1'b1;
    if4.D       = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (if4.Q !== 4'b0111) begin n_fail++; $display("FAIL rstmid_Q_before: got %b want 0111", if4.Q); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if4.amostra = 1'b0;
    n_checks++; if (if4.Q !== 4'b0000) begin n_fail++; $display("FAIL rstmid_Q: got %b want 0000", if4.Q); end
    n_checks++; if (if4.indice !== 2'd0) begin n_fail++; $display("FAIL rstmid_indice: got %0d want 0", if4.indice); end
    n_checks++; if (if4.ocupado !== 1'b0) begin n_fail++; $display("FAIL rstmid_ocupado: got %b want 0", if4.ocupado); end
    n_checks++; if (if4.pronto !== 1'b0) begin n_fail++; $display("FAIL rstmid_pronto: got %b want 0", if4.pronto); end
    tick();
    n_checks++; if (if4.pronto !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_pronto: got %b want 0", if4.pronto); end
    if4.iniciar = 1'b1;
    tick();
    if4.iniciar = 1'b0;
    if4.amostra = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if4.D = w[i];
      tick();
    end
    n_checks++; if (if4.pronto !== 1'b1) begin n_fail++; $display("FAIL ignore_pronto: got %b want 1", if4.pronto); end
    // Strobe with D=0 while in FIM, then twice in INICIAL.
    if4.D = 1'b0;
    tick();
    n_checks++; if (if4.Q !== 4'b1011) begin n_fail++; $display("FAIL ignore_fim_Q: got %b want 1011", if4.Q); end
    n_checks++; if (if4.ocupado !== 1'b0) begin n_fail++; $display("FAIL ignore_fim_ocupado: got %b want 0", if4.ocupado); end
    tick();
    tick();
    if4.amostra = 1'b0;
    n_checks++; if (if4.Q !== 4'b1011) begin n_fail++; $display("FAIL ignore_inicial_Q: got %b want 1011", if4.Q); end
    n_checks++; if (if4.indice !== 2'd0) begin n_fail++; $display("FAIL ignore_inicial_indice: got %0d want 0", if4.indice); end
  endtask

  task automatic test_sweep();
    int idx3[3];
    int idx5[5];
    idx3 = '{1, 2, 0};
    idx5 = '{1, 2, 3, 4, 0};
    if3.iniciar = 1'b1;
    tick();
    if3.iniciar = 1'b0;
    if3.amostra = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if3.D = ((i % 2) == 0);
      tick();
      n_checks++; if (int'(if3.indice) !== idx3[i]) begin n_fail++; $display("FAIL n3_indice%0d: got %0d want %0d", i, if3.indice, idx3[i]); end
    end
    if3.amostra = 1'b0;
    n_checks++; if (if3.Q !== 3'b101) begin n_fail++; $display("FAIL n3_Q: got %b want 101", if3.Q); end
    n_checks++; if (if3.pronto !== 1'b1) begin n_fail++; $display("FAIL n3_pronto: got %b want 1", if3.pronto); end
    tick();
    if5.iniciar = 1'b1;
    tick();
    if5.iniciar = 1'b0;
    if5.amostra = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if5.D = ((i % 2) == 0);
      tick();
      n_checks++; if (int'(if5.indice) !== idx5[i]) begin n_fail++; $display("FAIL n5_indice%0d: got %0d want %0d", i, if5.indice, idx5[i]); end
    end
    if5.amostra = 1'b0;
    n_checks++; if (if5.Q !== 5'b10101) begin n_fail++; $display("FAIL n5_Q: got %b want 10101", if5.Q); end
    n_checks++; if (if5.pronto !== 1'b1) begin n_fail++; $display("FAIL n5_pronto: got %b want 1", if5.pronto); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cycle    = 0;
    rst      = 1'b1;
    if4.iniciar = 1'b0; if4.amostra = 1'b0; if4.D = 1'b0;
    if3.iniciar = 1'b0; if3.amostra = 1'b0; if3.D = 1'b0;
    if5.iniciar = 1'b0; if5.amostra = 1'b0; if5.D = 1'b0;

    test_reset();
    test_basic();
    test_gapped();
    test_restart();
    test_back_to_back();
    test_reset_ignore();
    test_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
